// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-fronted ALU: opcodes and FSM state encodings.
package uart_alu_pkg;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  typedef enum logic [1:0] {
    SEQ_WAIT_A  = 2'd0,
    SEQ_WAIT_B  = 2'd1,
    SEQ_WAIT_OP = 2'd2,
    SEQ_SEND    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/uart_alu_top_baud_tick.sv
// Free-running baud tick generator: one-clock tick every DIV system clocks.
module uart_baud_tick #(
  parameter int DIV = 163
) (
  input  logic clk_i,
  input  logic rst_b_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_alu_top.sv
// UART front end for the 8-bit ALU: receives A, B, opcode bytes and transmits the result byte.
// state | meaning (RX/TX: IDLE, START, DATA, STOP; sequencer: WAIT_A, WAIT_B, WAIT_OP, SEND)
module uart_alu_top
  import uart_alu_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DIV     = 163,
  parameter int SIZ     = 8
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_data,
  output logic tx_done,
  output logic o_result
);

  localparam int TW = 6;
  localparam int NW = $clog2(DBIT) + 1;

  logic tick;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk_i   (i_clock),
    .rst_b_i (i_reset),
    .tick_o  (tick)
  );

  // Two-flop synchronizer on the asynchronous RX line; idles high.
  logic [1:0] rx_sync_q;
  logic       rx_line;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) rx_sync_q <= 2'b11;
    else          rx_sync_q <= {rx_sync_q[0], i_data};
  end

  assign rx_line = rx_sync_q[1];

  uart_state_e     rx_state_q, rx_state_d;
  logic [TW-1:0]   rx_s_q, rx_s_d;
  logic [NW-1:0]   rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic            rx_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      UART_IDLE: begin
        if (!rx_line) begin
          rx_state_d = UART_START;
          rx_s_d     = '0;
        end
      end
      UART_START: begin
        if (tick) begin
          if (rx_s_q == TW'(7)) begin
            if (!rx_line) begin
              rx_state_d = UART_DATA;
              rx_s_d     = '0;
              rx_n_d     = '0;
            end else begin
              rx_state_d = UART_IDLE;
            end
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      UART_DATA: begin
        if (tick) begin
          if (rx_s_q == TW'(15)) begin
            rx_s_d = '0;
            rx_b_d = {rx_line, rx_b_q[DBIT-1:1]};
            if (rx_n_q == NW'(DBIT - 1)) rx_state_d = UART_STOP;
            else                         rx_n_d     = rx_n_q + 1'b1;
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      UART_STOP: begin
        if (tick) begin
          if (rx_s_q == TW'(SB_TICK - 1)) begin
            rx_state_d = UART_IDLE;
            // A low stop bit is a framing error: the byte is silently dropped.
            rx_done    = rx_line;
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      default: rx_state_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_state_q <= UART_IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
    end
  end

  seq_state_e     seq_q, seq_d;
  logic [SIZ-1:0] a_q, a_d, b_q, b_d, op_q, op_d, res_q, res_d;
  logic [SIZ-1:0] alu_op, alu_y;
  logic           tx_start_q, tx_start_d;
  logic           tx_done_q, tx_done_d;

  // The ALU sees the opcode byte in the same clock it is latched.
  assign alu_op = (seq_q == SEQ_WAIT_OP && rx_done) ? rx_b_q : op_q;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      OP_ADD:  alu_y = a_q + b_q;
      OP_SUB:  alu_y = a_q - b_q;
      OP_AND:  alu_y = a_q & b_q;
      OP_OR:   alu_y = a_q | b_q;
      OP_XOR:  alu_y = a_q ^ b_q;
      OP_NOR:  alu_y = ~(a_q | b_q);
      OP_SRA:  alu_y = $unsigned($signed(a_q) >>> b_q);
      OP_SRL:  alu_y = a_q >> b_q;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    seq_d      = seq_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    tx_start_d = 1'b0;
    unique case (seq_q)
      SEQ_WAIT_A: begin
        if (rx_done) begin
          a_d   = rx_b_q;
          seq_d = SEQ_WAIT_B;
        end
      end
      SEQ_WAIT_B: begin
        if (rx_done) begin
          b_d   = rx_b_q;
          seq_d = SEQ_WAIT_OP;
        end
      end
      SEQ_WAIT_OP: begin
        if (rx_done) begin
          op_d       = alu_op;
          res_d      = alu_y;
          tx_start_d = 1'b1;
          seq_d      = SEQ_SEND;
        end
      end
      SEQ_SEND: begin
        if (tx_done_q) seq_d = SEQ_WAIT_A;
      end
      default: seq_d = SEQ_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      seq_q      <= SEQ_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      tx_start_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      tx_start_q <= tx_start_d;
    end
  end

  uart_state_e    tx_state_q, tx_state_d;
  logic [TW-1:0]  tx_s_q, tx_s_d;
  logic [NW-1:0]  tx_n_q, tx_n_d;
  logic [SIZ-1:0] tx_b_q, tx_b_d;
  logic           tx_q, tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    unique case (tx_state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (tx_start_q) begin
          tx_state_d = UART_START;
          tx_s_d     = '0;
          tx_b_d     = res_q;
          tx_d       = 1'b0;
        end
      end
      UART_START: begin
        if (tick) begin
          if (tx_s_q == TW'(15)) begin
            tx_state_d = UART_DATA;
            tx_s_d     = '0;
            tx_n_d     = '0;
            tx_d       = tx_b_q[0];
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      UART_DATA: begin
        if (tick) begin
          if (tx_s_q == TW'(15)) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == NW'(DBIT - 1)) begin
              tx_state_d = UART_STOP;
              tx_d       = 1'b1;
            end else begin
              tx_n_d = tx_n_q + 1'b1;
              tx_d   = tx_b_q[1];
            end
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      UART_STOP: begin
        if (tick) begin
          if (tx_s_q == TW'(SB_TICK - 1)) begin
            tx_state_d = UART_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      default: tx_state_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tx_state_q <= UART_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign o_result = tx_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_alu_top.sv
// Directed bench for uart_alu_top: serial A/B/OP frames in, decoded TX frame checked against hand values.
module tb_uart_alu_top;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  logic clk;
  logic i_reset;
  logic i_data;
  logic tx_done;
  logic o_result;

  int n_cmp = 0;
  int n_err = 0;
  int done_cycles = 0;
  logic [8:0] txq[$];

  uart_alu_top #(
    .DBIT(8), .SB_TICK(16), .DIV(DIV), .SIZ(8)
  ) dut (
    .i_clock  (clk),
    .i_reset  (i_reset),
    .i_data   (i_data),
    .tx_done  (tx_done),
    .o_result (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done) done_cycles++;

  // Decode TX frames at mid-bit; each entry is {stop_bit, data}.
  initial begin
    logic [7:0] d;
    logic       s;
    forever begin
      @(negedge o_result);
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        d[i] = o_result;
      end
      repeat (BIT) @(negedge clk);
      s = o_result;
      txq.push_back({s, d});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b);
    i_data = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_data = d[i];
      repeat (BIT) @(negedge clk);
    end
    i_data = stop_b;
    repeat (BIT) @(negedge clk);
    i_data = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    i_data = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic expect_result(input string tag, input logic [7:0] exp, input int base);
    int waited;
    logic [8:0] fr;
    waited = 0;
    while (txq.size() == 0 && waited < 30 * BIT) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, " frames"}, txq.size(), 1);
    if (txq.size() > 0) begin
      fr = txq.pop_front();
      check_eq({tag, " data"}, fr[7:0], exp);
      check_eq({tag, " stop"}, fr[8], 1);
    end
    repeat (BIT) @(negedge clk);
    check_eq({tag, " tx_done cycles"}, done_cycles - base, 1);
    check_eq({tag, " idle line"}, o_result, 1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input logic [7:0] exp);
    int base;
    base = done_cycles;
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(op, 1'b1);
    expect_result(tag, exp, base);
  endtask

  initial begin
    int base;
    i_reset = 1'b0;
    i_data  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset o_result", o_result, 1);
    check_eq("reset tx_done", tx_done, 0);
    i_reset = 1'b1;
    idle_bits(2);

    run_op("add", 8'h14, 8'h07, 8'h20, 8'h1B);
    run_op("sub", 8'h14, 8'h07, 8'h22, 8'h0D);
    run_op("sra", 8'h80, 8'h02, 8'h03, 8'hE0);
    run_op("srl", 8'h80, 8'h02, 8'h02, 8'h20);
    run_op("nor", 8'hF0, 8'h3C, 8'h27, 8'h03);
    run_op("xor", 8'hF0, 8'h3C, 8'h26, 8'hCC);
    run_op("bad op", 8'hF0, 8'h3C, 8'h55, 8'h00);

    // Stop bit low: byte must be dropped; idle gap lets the receiver realign.
    base = done_cycles;
    send_byte(8'h55, 1'b0);
    idle_bits(2);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h20, 1'b1);
    expect_result("framing", 8'h03, base);

    // Short low pulse must not be taken as a start bit.
    i_data = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    idle_bits(2);
    run_op("glitch or", 8'h0F, 8'hF0, 8'h25, 8'hFF);

    // Reset in the middle of the B frame.
    send_byte(8'h33, 1'b1);
    i_data = 1'b0;
    repeat (BIT) @(negedge clk);
    i_data = 1'b1;
    repeat (3 * BIT + BIT / 2) @(negedge clk);
    i_reset = 1'b0;
    #1;
    check_eq("mid reset o_result", o_result, 1);
    check_eq("mid reset tx_done", tx_done, 0);
    repeat (4) @(negedge clk);
    i_reset = 1'b1;
    idle_bits(2);
    check_eq("post reset no frame", txq.size(), 0);
    run_op("after reset and", 8'h14, 8'h07, 8'h24, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_alu_top.md
# uart_alu_top

Serial front end for the 8-bit ALU. It receives three UART bytes on `i_data`: operand A, operand B, then the opcode. It computes the result and transmits it back as one UART byte on `o_result`. It contains the baud tick generator, the receiver, the sequencing FSM, the ALU and the transmitter.

## Interface
Parameters:
- `DBIT`, 8: data bits per UART frame.
- `SB_TICK`, 16: stop-bit length in baud ticks (16 = 1 stop bit).
- `DIV`, 163: system clocks per baud tick (16 ticks per bit).
- `SIZ`, 8: ALU operand/result width. It must equal `DBIT`.

Ports:
- `i_clock`, in, 1: system clock, rising edge.
- `i_reset`, in, 1: reset, asynchronous, active-low.
- `i_data`, in, 1: UART RX line, idle high.
- `tx_done`, out, 1: one-clock pulse when the result frame's stop bit completes. Reset value 0.
- `o_result`, out, 1: UART TX line. Reset value 1 (idle).

## Operation
- **Tick generator:** a free-running counter counts 0..DIV-1. `tick` pulses for one clock when the count equals DIV-1, then the counter wraps to 0. The counter clears on reset.
- **Receiver** (states IDLE, START, DATA, STOP):
  - IDLE→START on `i_data`=0.
  - In START, after 7 ticks: if the line is still low, clear the tick count and go to DATA. Otherwise return to IDLE (glitch).
  - In DATA, sample every 16 ticks and shift right, LSB first, for DBIT bits.
  - In STOP, after SB_TICK ticks: pulse `rx_done` (internal) and go to IDLE.
  - Framing error: if the stop bit is sampled 0, drop the byte (no `rx_done`) and go to IDLE.
- **Sequencer** (states WAIT_A, WAIT_B, WAIT_OP, SEND):
  - Each `rx_done` latches the byte into A, B or OP and advances the state.
  - In WAIT_OP, `rx_done` latches OP, registers `result = alu(A,B,OP)`, pulses `tx_start` for one clock and enters SEND.
  - On `tx_done`, SEND→WAIT_A.
  - Bytes received while in SEND are discarded.
- **ALU:** combinational on SIZ bits; the result is truncated to SIZ bits and carry is discarded.
  - 0x20 ADD A+B.
  - 0x22 SUB A-B.
  - 0x24 AND.
  - 0x25 OR.
  - 0x26 XOR.
  - 0x27 NOR.
  - 0x03 SRA: A arithmetic-shifted right by B.
  - 0x02 SRL: A logical-shifted right by B.
  - Any other opcode gives 0.
- **Transmitter** (states IDLE, START, DATA, STOP):
  - On `tx_start` in IDLE, load the result and drive 0.
  - START lasts 16 ticks; DATA sends DBIT bits LSB first, 16 ticks each; STOP drives 1 for SB_TICK ticks.
  - Then pulse `tx_done` for one clock and return to IDLE.
  - `tx_start` while busy is ignored.

## Timing
- One bit = 16·DIV clocks (2608 at defaults). The receiver samples at mid-bit.
- `rx_done` on the opcode byte → `tx_start` next clock → `o_result` low on the following clock. The start-bit tick count then begins.
- `tx_done` is asserted in the clock after the final stop tick.
- Asynchronous reset (`i_reset`=0) at any time, including mid-frame:
  - all FSMs return to IDLE/WAIT_A;
  - A, B, OP and result clear to 0;
  - `o_result`=1, `tx_done`=0.
- Back-to-back RX frames with no idle gap must be received.

## Structure
- Shared package `uart_alu_pkg` holds:
  - the opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL);
  - the RX/TX state enum;
  - the sequencer state enum.
- One natural sub-module is `uart_baud_tick` (parameter DIV).
- The receiver, transmitter, sequencer and ALU are written inline in `uart_alu_top`.

## Test plan
- **ADD:** send frames A=0x14, B=0x07, OP=0x20 → one TX frame carrying 0x1B, then one `tx_done` pulse, then the line idles high.
- **SUB and SRA:** A=0x14, B=0x07, OP=0x22 → 0x0D. A=0x80, B=0x02, OP=0x03 → 0xE0.
- **Logic ops and invalid opcode:** A=0xF0, B=0x3C, OP=0x27 → 0x03. OP=0x55 → 0x00.
- **Framing error:** an A frame with stop bit 0 is dropped. The next three valid frames (0x01, 0x02, 0x20) → 0x03.
- **Glitch:** a 3-tick low pulse on `i_data` does not start a frame. A subsequent A/B/OP sequence then computes correctly.
- **Reset:** assert `i_reset` low mid-way through the B frame → `o_result`=1 and `tx_done`=0 immediately. After release, a full new A/B/OP sequence yields the correct result.
